// File: rtl/control_vidas_pkg.sv
// Shared game definitions for the lives/grace controller: state encoding,
// parameter defaults and the life-count helper.
package control_vidas_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    HIT  = 3'd2,
    OVER = 3'd3,
    WIN  = 3'd4
  } state_t;

  localparam logic [1:0] LIVES_INIT_DEF   = 2'd3;
  localparam logic [7:0] GRACE_FRAMES_DEF = 8'd60;
  localparam logic [7:0] BLINK_FRAMES_DEF = 8'd8;

  // Remove one life, pinned at zero so the count can never wrap.
  function automatic logic [1:0] lose_life(input logic [1:0] cur);
    lose_life = (cur == 2'd0) ? 2'd0 : cur - 2'd1;
  endfunction

endpackage

// File: rtl/grace_timer.sv
// Post-hit invulnerability timer: counts frame ticks after a clear pulse,
// flags the final tick and produces the heart blink phase while running.
module grace_timer
  import control_vidas_pkg::*;
#(
  parameter logic [7:0] GRACE_FRAMES = GRACE_FRAMES_DEF,
  parameter logic [7:0] BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic refr_tick,
  output logic done,
  output logic blink
);

  logic       run;
  logic [7:0] grace_cnt;
  logic [7:0] blink_cnt;
  logic       last_tick;
  logic       blink_wrap;

  assign last_tick  = (grace_cnt == GRACE_FRAMES - 8'd1);
  assign blink_wrap = (blink_cnt == BLINK_FRAMES - 8'd1);
  assign done       = run & refr_tick & ~clear & last_tick;

  // A clear (re)starts a grace window with the hearts blanked; outside a
  // window ticks are ignored and the gate rests high.
  always_ff @(posedge clk) begin
    if (reset) begin
      run       <= 1'b0;
      grace_cnt <= 8'd0;
      blink_cnt <= 8'd0;
      blink     <= 1'b1;
    end else if (clear) begin
      run       <= 1'b1;
      grace_cnt <= 8'd0;
      blink_cnt <= 8'd0;
      blink     <= 1'b0;
    end else if (run && refr_tick) begin
      if (last_tick) begin
        run       <= 1'b0;
        grace_cnt <= 8'd0;
        blink_cnt <= 8'd0;
        blink     <= 1'b1;
      end else begin
        grace_cnt <= grace_cnt + 8'd1;
        if (blink_wrap) begin
          blink_cnt <= 8'd0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/control_vidas.sv
// Lives controller for the maze game: tracks lives, collision hits with a
// grace window, and the game-over / win end states.
module control_vidas
  import control_vidas_pkg::*;
#(
  parameter logic [1:0] LIVES_INIT   = LIVES_INIT_DEF,
  parameter logic [7:0] GRACE_FRAMES = GRACE_FRAMES_DEF,
  parameter logic [7:0] BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       refr_tick,
  input  logic       collision,
  input  logic       goal,
  output logic [1:0] lives,
  output logic       playing,
  output logic       blink,
  output logic       hit,
  output logic       game_over,
  output logic       win
);

  state_t state;
  logic   enter_hit;
  logic   grace_done;

  // The grace window restarts on the same edge that moves PLAY into HIT.
  assign enter_hit = (state == PLAY) && collision && (lives > 2'd1);

  grace_timer #(
    .GRACE_FRAMES(GRACE_FRAMES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_grace (
    .clk      (clk),
    .reset    (reset),
    .clear    (enter_hit),
    .refr_tick(refr_tick),
    .done     (grace_done),
    .blink    (blink)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lives     <= LIVES_INIT;
      hit       <= 1'b0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      hit <= 1'b0;
      case (state)
        IDLE: begin
          lives <= LIVES_INIT;
          if (start) begin
            state   <= PLAY;
            playing <= 1'b1;
          end
        end
        PLAY: begin
          // Collision wins over goal when both arrive together.
          if (collision) begin
            hit   <= 1'b1;
            lives <= lose_life(lives);
            if (lives > 2'd1) begin
              state <= HIT;
            end else begin
              state     <= OVER;
              playing   <= 1'b0;
              game_over <= 1'b1;
            end
          end else if (goal) begin
            state   <= WIN;
            playing <= 1'b0;
            win     <= 1'b1;
          end
        end
        HIT: begin
          if (grace_done) state <= PLAY;
        end
        OVER: begin
          if (start) begin
            state     <= IDLE;
            lives     <= LIVES_INIT;
            game_over <= 1'b0;
          end
        end
        WIN: begin
          if (start) begin
            state <= IDLE;
            lives <= LIVES_INIT;
            win   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          lives     <= LIVES_INIT;
          playing   <= 1'b0;
          game_over <= 1'b0;
          win       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_vidas.sv
// Scoreboard bench for control_vidas: directed stimulus pushes hand-computed
// expectations tagged with their cycle; a monitor pops and compares them.
module tb_control_vidas;

  logic       clk = 1'b0;
  logic       reset, start, refr_tick, collision, goal;
  logic [1:0] lives;
  logic       playing, blink, hit, game_over, win;

  control_vidas dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .refr_tick(refr_tick),
    .collision(collision),
    .goal     (goal),
    .lives    (lives),
    .playing  (playing),
    .blink    (blink),
    .hit      (hit),
    .game_over(game_over),
    .win      (win)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic stim_done = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  // Inputs change just after an edge and are sampled on the following edge.
  task automatic step(input logic r, input logic s, input logic t,
                      input logic c, input logic g);
    @(posedge clk);
    #1;
    reset = r; start = s; refr_tick = t; collision = c; goal = g;
  endtask

  // Expected outputs after the edge that samples the inputs just driven.
  task automatic chk(input string nm, input logic [1:0] l, input logic p,
                     input logic b, input logic h, input logic go,
                     input logic w);
    exp_t e;
    e.cyc  = cyc + 1;
    e.vec  = {l, p, b, h, go, w};
    e.name = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(posedge clk);
      #2;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        act = {lives, playing, blink, hit, game_over, win};
        n_tests++;
        if (act !== e.vec) begin
          n_fail++;
          $display("FAIL %s: got lives=%0d play=%b blink=%b hit=%b over=%b win=%b, want lives=%0d play=%b blink=%b hit=%b over=%b win=%b",
                   e.name, act[6:5], act[4], act[3], act[2], act[1], act[0],
                   e.vec[6:5], e.vec[4], e.vec[3], e.vec[2], e.vec[1], e.vec[0]);
        end
      end
    end
  end

  initial begin : stimulus
    logic bexp;
    reset = 1'b1; start = 1'b0; refr_tick = 1'b0; collision = 1'b0; goal = 1'b0;

    step(1, 0, 0, 0, 0); chk("reset", 2'd3, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0); chk("start", 2'd3, 1, 1, 0, 0, 0);

    // Collision held for 500 cycles costs a single life.
    for (int i = 0; i < 500; i++) begin
      step(0, 0, 0, 1, 0);
      if (i == 0) chk("hit_entry", 2'd2, 1, 0, 1, 0, 0);
      else        chk("coll_held", 2'd2, 1, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0); chk("hit_idle", 2'd2, 1, 0, 0, 0, 0);

    // Full grace window: blink follows (k/8) mod 2, PLAY after tick 60.
    for (int k = 1; k <= 60; k++) begin
      step(0, 0, 1, 0, 0);
      bexp = (k < 60) ? (((k / 8) % 2) == 1) : 1'b1;
      chk("grace_tick", 2'd2, 1, bexp, 0, 0, 0);
      if (k == 10) begin
        step(0, 0, 0, 1, 1); chk("hit_ignores_goal", 2'd2, 1, 1, 0, 0, 0);
      end else if (k == 59) begin
        step(0, 0, 0, 1, 0); chk("hit_ignores_coll", 2'd2, 1, 1, 0, 0, 0);
      end else begin
        step(0, 0, 0, 0, 0);
      end
    end

    step(0, 1, 1, 0, 0); chk("play_start_tick", 2'd2, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 1); chk("coll_goal_tick", 2'd1, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 60; k++) begin
      step(0, 0, 1, 0, 0);
      if (k == 60) chk("grace2_end", 2'd1, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end

    step(0, 0, 0, 1, 0); chk("last_life", 2'd0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1); chk("over_hold", 2'd0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0); chk("over_restart", 2'd3, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0); chk("play_again", 2'd3, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1); chk("goal_win", 2'd3, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0); chk("win_hold", 2'd3, 0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0); chk("win_restart", 2'd3, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0); chk("play_third", 2'd3, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0); chk("hit_third", 2'd2, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    step(0, 1, 0, 0, 0); chk("hit_ignores_start", 2'd2, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0); chk("reset_mid_hit", 2'd3, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0); chk("idle_tick", 2'd3, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0); chk("play_after_reset", 2'd3, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0); chk("hit_after_reset", 2'd2, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    stim_done = 1'b1;
  end

  initial begin : finisher
    int guard = 0;
    while (!stim_done && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #3;
    n_tests++;
    if (!stim_done || q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: stim_done=%b pending=%0d, want stim_done=1 pending=0",
               stim_done, q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
